// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
// Honours SERIAL_RX_PARITY_EN: adds the PARITY state when defined.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_bit_counter.sv
// Strobed, clearable data-bit counter; tc marks the strobe that brings
// the count up to N, so the FSM can leave DATA on the Nth bit itself.
module rx_bit_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

    assign tc = en && (count == CW'(N - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// LSB-first serial frame receiver with valid/ready output and sticky overrun.
// Build option SERIAL_RX_PARITY_EN adds an even-parity bit before the stop bit.
module serial_frame_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         si,
    input  logic         ready,
    input  logic         clr_overrun,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);

    import serial_pkg::*;

    rx_state_t    state, state_nxt;
    logic [N-1:0] shreg;
    logic         par_bad;
    logic         cnt_clr, cnt_en, cnt_last;
    logic         stop_smp, good_frame, frame_bad;

    rx_bit_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .tc    (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        if (bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (si == START_BIT) begin
                        state_nxt = ST_DATA;
                        cnt_clr   = 1'b1;
                    end
                end
                ST_DATA: begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: state_nxt = ST_STOP;
`endif
                ST_STOP: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Data arrives LSB first, so shifting in at the MSB leaves bit 0 = first bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shreg <= '0;
        else if (bit_en && state == ST_DATA)
            shreg <= {si, shreg[N-1:1]};
    end

`ifdef SERIAL_RX_PARITY_EN
    logic parity_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            par_bad <= 1'b0;
        else if (bit_en && state == ST_IDLE && si == START_BIT)
            par_bad <= 1'b0;
        else if (bit_en && state == ST_PARITY)
            par_bad <= (^shreg) ^ si;
    end

    assign parity_bad = stop_smp && si == STOP_BIT && par_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_err <= 1'b0;
        else
            parity_err <= parity_bad;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign stop_smp   = bit_en && state == ST_STOP;
    assign good_frame = stop_smp && si == STOP_BIT && !par_bad;
    assign frame_bad  = stop_smp && si != STOP_BIT;

    // A completing frame may replace the held word only if it is being accepted now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            if (good_frame && (!valid || ready)) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (good_frame && valid && !ready)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver that consumes the LSB-first bitstream produced by the team's parallel-load shift-right register (its `so` output). It detects a start bit, assembles N data bits, checks the stop bit (and, optionally, parity), and presents the word on a valid/ready output port. It is the receive stage directly downstream of the transmit shift register.

## Interface
- `N`, default 4: data bits per frame; must be ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; forces every register to its reset value.
- `bit_en`  in  1: bit strobe; `si` is sampled only on cycles with `bit_en`=1. Tie high for one bit per clock.
- `si`  in  1: serial line; idles high.
- `ready`  in  1: downstream accepts `data_out` when `valid`=1 and `ready`=1.
- `clr_overrun`  in  1: synchronous clear of `overrun`.
- `data_out`  out  N: received word; bit 0 is the first data bit received.
- `valid`  out  1: `data_out` holds an unaccepted word.
- `frame_err`  out  1: one-cycle pulse; stop bit was sampled as 0.
- `parity_err`  out  1: one-cycle pulse; parity mismatch. Constant 0 without the parity feature.
- `overrun`  out  1: sticky; a good frame was dropped because `valid`=1 and `ready`=0.

## Operation
- Frame on strobed samples: start (0), N data bits LSB first, [parity], stop (1).
- FSM states: IDLE, DATA, PARITY (parity builds only), STOP. Transitions occur only on strobed cycles.
- IDLE: a sample of 0 moves to DATA and clears the bit counter; a sample of 1 stays in IDLE.
- DATA: shift the sample in at the MSB of the assembly register (shift right), counter +1. After the Nth bit, go to PARITY or STOP. Counter width is $clog2(N+1).
- PARITY: compare the sample with the even parity of the N data bits (XOR of data and the parity bit must be 0). Record any mismatch; go to STOP.
- STOP: always return to IDLE.
  - Sample 0: pulse `frame_err` and discard the word. The next strobed 0 in IDLE is treated as a new start bit.
  - Sample 1 with a recorded parity mismatch: pulse `parity_err` and discard the word.
  - Sample 1, no mismatch: the frame is good.
- Good frame with `valid`=0, or with `valid`=1 and `ready`=1 in the same cycle: load `data_out`, and `valid`=1.
- Good frame with `valid`=1 and `ready`=0: drop the new word, keep the old `data_out`, set `overrun`.
- Handshake: `valid` stays 1 and `data_out` stays stable until `valid`&`ready`. `valid` then deasserts the next cycle unless a good frame completes in that same cycle.
- `clr_overrun` and an overrun event in the same cycle: `overrun` ends at 1 (set wins).
- `bit_en`=0: FSM, counter and assembly register hold. The output handshake still operates.

## Timing
- Reset values: `data_out`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. Internal state: IDLE, counter 0.
- Reset mid-frame abandons the frame with no error pulse.
- Latency: `valid` rises on the clock edge that samples the stop bit. With `bit_en`=1, that is N+1 (or N+2 with parity) cycles after the start-bit edge.
- Error pulses are registered and last exactly one cycle, on the same edge the stop bit is sampled.
- There is no combinational path from any input to any output.
- Throughput: back-to-back frames, with no idle bit required between stop and next start.

## Configuration
- `SERIAL_RX_PARITY_EN` defined: the PARITY state and the even-parity check are compiled in, the frame is N+3 bits, and `parity_err` is live.
- `SERIAL_RX_PARITY_EN` undefined: there is no PARITY state, the frame is N+2 bits, and `parity_err` is tied to 0.
- Port list is identical in both builds.

## Structure
- Package `serial_pkg`:
  - FSM state enum `rx_state_t`.
  - Constants `START_BIT`=1'b0, `STOP_BIT`=1'b1, `IDLE_LEVEL`=1'b1.
- Sub-module `rx_bit_counter`: strobed, clearable up-counter with a terminal-count flag at N. It holds the only counter arithmetic.
- FSM, assembly register and output register live in the top module.

## Test plan
- N=4, `bit_en`=1. Drive `si` = 1,1,0,0,1,0,1,1 → `data_out`=4'hA, `valid`=1 after the edge that samples the final 1 (the stop bit); no error flags.
- Same frame but the stop bit driven 0 → `frame_err` pulses for 1 cycle, `valid` stays 0, FSM returns to IDLE.
- Hold `ready`=0 and send 4'h3, then 4'h5 → `data_out` stays 4'h3, `overrun`=1. Pulse `clr_overrun` → `overrun`=0.
- Send 4'h6 back-to-back with 4'h9, with `ready`=1 on the cycle 4'h9's stop bit is sampled → `data_out`=4'h9, `valid` stays 1, no overrun.
- With `SERIAL_RX_PARITY_EN`, send 4'h7 with parity bit 0 → `parity_err` pulses and the word is dropped. With parity bit 1 → `data_out`=4'h7.
- Assert `reset` after two data bits, release it, then send 4'hC → `data_out`=4'hC, `valid`=1, no error pulses; `bit_en` toggling at 1/3 duty gives the same result.
